// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU codes, datapath width and the
// execute-stage result packet.
package cpu_pkg;

  localparam int WIDTH = 16;
  localparam int RD_W  = 3;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_NOT = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             illegal;
  } alu_pkt_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: turns code and operands into a complete
// result packet including flags.
module alu_core
  import cpu_pkg::*;
(
  input  logic [2:0]       alu_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [RD_W-1:0]  rd,
  output alu_pkt_t         pkt
);

  localparam int MSB = WIDTH - 1;

  logic             is_add;
  logic             is_sub;
  logic             is_and;
  logic             is_or;
  logic             is_not;
  logic             is_xor;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             c;
  logic             v;
  logic             ill;

  assign is_add = (alu_code == ALU_ADD);
  assign is_sub = (alu_code == ALU_SUB);
  assign is_and = (alu_code == ALU_AND);
  assign is_or  = (alu_code == ALU_OR);
  assign is_not = (alu_code == ALU_NOT);
  assign is_xor = (alu_code == ALU_XOR);

  // Subtract is a + ~b + 1, so carry out means no borrow.
  assign bx  = is_sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx}
             + {{WIDTH{1'b0}}, is_sub};

  always_comb begin
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    ill = 1'b0;
    unique case (1'b1)
      is_add, is_sub: begin
        res = sum[MSB:0];
        c   = sum[WIDTH];
        v   = (a[MSB] == bx[MSB])
            && (sum[MSB] != a[MSB]);
      end
      is_and:  res = a & b;
      is_or:   res = a | b;
      is_not:  res = ~a;
      is_xor:  res = a ^ b;
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    pkt         = '0;
    pkt.result  = res;
    pkt.rd      = rd;
    pkt.z       = (res == '0);
    pkt.n       = res[MSB];
    pkt.c       = c;
    pkt.v       = v;
    pkt.illegal = ill;
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Execute stage: ALU plus main/skid output buffering so that
// in_ready is a flop and never depends on out_ready.
module alu_exec_stage #(
  parameter int WIDTH = 16,
  parameter int RD_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_code,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [RD_W-1:0]  in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [RD_W-1:0]  out_rd,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  import cpu_pkg::*;

  alu_pkt_t         pkt;
  alu_pkt_t         main_q;
  alu_pkt_t         main_d;
  alu_pkt_t         skid_q;
  alu_pkt_t         skid_d;
  logic             main_v;
  logic             main_vd;
  logic             skid_v;
  logic             skid_vd;
  logic             rdy_q;
  logic             acc;
  logic             drn;
  logic [CNT_W-1:0] cnt_q;

  alu_core u_core (
    .alu_code (alu_code),
    .a        (op_a),
    .b        (op_b),
    .rd       (in_rd),
    .pkt      (pkt)
  );

  assign acc = in_valid && rdy_q;
  assign drn = main_v && out_ready;

  // rdy_q == !skid_v, so accept with drain and a full skid
  // never happens.
  always_comb begin
    main_d  = main_q;
    main_vd = main_v;
    skid_d  = skid_q;
    skid_vd = skid_v;
    if (drn) begin
      if (skid_v) begin
        main_d  = skid_q;
        skid_vd = 1'b0;
      end else if (acc) begin
        main_d  = pkt;
      end else begin
        main_vd = 1'b0;
      end
    end else if (acc) begin
      if (!main_v) begin
        main_d  = pkt;
        main_vd = 1'b1;
      end else begin
        skid_d  = pkt;
        skid_vd = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
      cnt_q  <= '0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_v <= main_vd;
      skid_v <= skid_vd;
      rdy_q  <= !skid_vd;
      if (drn) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign in_ready      = rdy_q;
  assign out_valid     = main_v;
  assign result        = main_q.result;
  assign out_rd        = main_q.rd;
  assign flag_z        = main_q.z;
  assign flag_n        = main_q.n;
  assign flag_c        = main_q.c;
  assign flag_v        = main_q.v;
  assign illegal       = main_q.illegal;
  assign retired_count = cnt_q;

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute stage of the 16-bit CPU.
- Consumes the 3-bit ALU code from the ALU control decoder, plus the two operands and the destination register index from decode.
- Performs the ALU operation and registers the result, flags and destination for writeback.
- Valid/ready handshake on both sides; a 2-entry skid buffer keeps in_ready registered (no combinational ready path through the stage).

Parameters:
- WIDTH, 16, datapath width in bits
- RD_W, 3, destination register index width
- CNT_W, 16, width of retired-operation counter

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  upstream has an operation
- in_ready  out  1  stage can accept; registered
- alu_code  in  3  000 add, 001 sub, 100 and, 101 or, 110 not, 111 xor; 010/011 illegal
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B (immediate already muxed in for addi)
- in_rd  in  RD_W  destination register index
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- result  out  WIDTH  ALU result
- out_rd  out  RD_W  destination index, travels with result
- flag_z  out  1  result == 0
- flag_n  out  1  result[WIDTH-1]
- flag_c  out  1  carry out (add); no-borrow (sub); 0 otherwise
- flag_v  out  1  signed overflow (add/sub); 0 otherwise
- illegal  out  1  operation carried code 010 or 011
- retired_count  out  CNT_W  number of output handshakes, wraps

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). All state clears on rst_n low regardless of clk.
- Reset values: in_ready=1, out_valid=0, skid empty, result/out_rd/all flags/illegal=0, retired_count=0.
- Arithmetic, computed combinationally on input fields and captured as a packet {result, rd, z, n, c, v, illegal}:
  - add: {c, result} = a + b, WIDTH+1 bits.
  - sub: {c, result} = a + ~b + 1; c=1 means no borrow.
  - v = (a[msb] == b'[msb]) && (result[msb] != a[msb]), with b' = b for add and ~b for sub.
  - and/or/xor: bitwise on a, b. not: ~a, b ignored. Logic ops force c=v=0.
  - Illegal codes: result=0, c=v=0, illegal=1; z follows result, so z=1.
  - z and n are always derived from the final result.
- Storage: main register (drives outputs) plus skid register.
- Accept: in_valid && in_ready.
  - If main is empty, or main is draining this cycle (out_ready) with skid empty, the packet goes to main.
  - Otherwise it goes to skid.
- Drain: out_valid && out_ready.
  - On drain, main loads skid if skid is full, else it loads the incoming packet if one is accepted, else it empties.
- in_ready next = !(skid full next cycle).
  - Deasserts the cycle after skid fills; reasserts the cycle after skid empties.
- Latency: 1 cycle from accept to out_valid when main is empty. Full throughput of 1 op/cycle when out_ready is held high.
- Simultaneous accept and drain with skid full cannot occur (in_ready=0 in that case).
- Outputs hold stable while out_valid && !out_ready.
- retired_count increments by 1 on each drain; wraps from 2^CNT_W-1 to 0.
- No flush port. Reset mid-operation discards both entries.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU code localparams: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b100, ALU_OR=3'b101, ALU_NOT=3'b110, ALU_XOR=3'b111. The ALU control decoder uses the same constants.
  - WIDTH default.
  - Packed struct alu_pkt_t {result, rd, z, n, c, v, illegal}.
- One natural sub-module: alu_core, purely combinational (alu_code, a, b -> alu_pkt_t fields). The skid/handshake logic lives in alu_exec_stage.

Test Plan:
- Reset then add 0x7FFF+0x0001, rd=3, out_ready=1 -> next cycle out_valid=1, result=0x8000, n=1, v=1, c=0, z=0, out_rd=3, retired_count=1 after handshake.
- sub 0x0005-0x0005 -> result=0x0000, z=1, c=1, v=0; sub 0x0000-0x0001 -> result=0xFFFF, c=0, n=1.
- Logic ops on a=0xF0F0, b=0x0FF0: and 0x00F0, or 0xFFF0, xor 0xFF00, not 0x0F0F; c=v=0 for each. Code 010 -> result=0, illegal=1, z=1.
- Backpressure: out_ready=0, in_valid=1 for 3 cycles (ops A, B, C).
  - A is held in main and B in skid; in_ready=0 from the cycle after B is accepted; C is held upstream.
  - Raise out_ready: outputs A, B, C in order, no loss or duplication.
- Streaming 100 back-to-back adds with out_ready=1 -> 100 results on consecutive cycles, in_ready never low, retired_count=100.
- Assert rst_n=0 mid-stream with both entries full, asynchronously between edges -> out_valid=0, in_ready=1, retired_count=0 immediately. No stale result appears after reset release.
